bram_fifo_fwft: RTL and testbench

- Synchronous first-word-fall-through FIFO controller built around the codebase's single-clock true dual-port BRAM (bram_dp_true_1clk).
- Port A is the write side and port B is the read side.
- It sits directly upstream of the BRAM, generating every addr/data/we/en signal for both ports.
- It hides the BRAM's 1-cycle registered read latency behind a valid/ready stream interface on both sides.

---
 rtl/bram_fifo_pkg.sv | 20 ++
 rtl/bram_dp_true_1clk.sv | 43 ++++
 rtl/bram_fifo_fwft.sv | 95 +++++++++
 tb/tb_bram_fifo_fwft.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_fifo_pkg.sv
// Shared defaults, types and pointer helper for the BRAM-backed FWFT FIFO.
package bram_fifo_pkg;

    localparam int RAM_WIDTH_DEF     = 16;
    localparam int RAM_ADDR_BITS_DEF = 3;

    typedef logic [RAM_ADDR_BITS_DEF:0] fifo_cnt_t;

    // Modulo subtraction of two wrap-bit pointers of width w (w <= 32).
    function automatic logic [31:0] ptr_diff(
        input logic [31:0] a,
        input logic [31:0] b,
        input int unsigned w
    );
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/bram_dp_true_1clk.sv
// Single-clock true dual-port block RAM with registered, read-first outputs.
module bram_dp_true_1clk
    import bram_fifo_pkg::*;
#(
    parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
    parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF
) (
    input  logic                     clk_i,
    input  logic                     en_a_i,
    input  logic                     we_a_i,
    input  logic [RAM_ADDR_BITS-1:0] addr_a_i,
    input  logic [RAM_WIDTH-1:0]     data_a_i,
    input  logic                     en_b_i,
    input  logic                     we_b_i,
    input  logic [RAM_ADDR_BITS-1:0] addr_b_i,
    input  logic [RAM_WIDTH-1:0]     data_b_i,
    output logic [RAM_WIDTH-1:0]     data_b_o
);

    localparam int DEPTH = 2 ** RAM_ADDR_BITS;

    logic [RAM_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [RAM_WIDTH-1:0] r_data_b;

    always_ff @(posedge clk_i) begin
        if (en_a_i && we_a_i) begin
            r_mem[addr_a_i] <= data_a_i;
        end
        if (en_b_i && we_b_i) begin
            r_mem[addr_b_i] <= data_b_i;
        end
    end

    // Output register only updates on an enabled read, so it holds otherwise.
    always_ff @(posedge clk_i) begin
        if (en_b_i && !we_b_i) begin
            r_data_b <= r_mem[addr_b_i];
        end
    end

    assign data_b_o = r_data_b;

endmodule

// File: rtl/bram_fifo_fwft.sv
// First-word-fall-through FIFO controller over a 1-cycle-latency dual-port BRAM.
module bram_fifo_fwft
    import bram_fifo_pkg::*;
#(
    parameter  int RAM_WIDTH     = RAM_WIDTH_DEF,
    parameter  int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
    localparam int CNT_W         = RAM_ADDR_BITS + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 flush_i,
    input  logic [RAM_WIDTH-1:0] s_data_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    output logic [RAM_WIDTH-1:0] m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [CNT_W-1:0]     count_o
);

    localparam int                  PTR_W     = RAM_ADDR_BITS + 1;
    localparam int unsigned         DEPTH     = 2 ** RAM_ADDR_BITS;
    localparam logic [PTR_W-1:0]    FULL_USED = PTR_W'(DEPTH);

    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic                 r_m_valid;
    logic [CNT_W-1:0]     r_count;

    logic [PTR_W-1:0]     w_used;
    logic                 w_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_rd_issue;
    logic [RAM_WIDTH-1:0] w_rd_data;

    assign w_used  = PTR_W'(ptr_diff(32'(r_wr_ptr), 32'(r_rd_ptr), PTR_W));
    assign w_ready = (w_used != FULL_USED);

    // Both BRAM ports are gated by reset and flush so neither issues an access then.
    assign w_push     = s_valid_i & w_ready & ~flush_i & rst_n_i;
    assign w_pop      = r_m_valid & m_ready_i;
    assign w_rd_issue = (w_used != '0) & (~r_m_valid | m_ready_i) & ~flush_i & rst_n_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_m_valid <= 1'b0;
            r_count   <= '0;
        end else if (flush_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_m_valid <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_issue) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_m_valid <= 1'b1;
            end else if (w_pop) begin
                r_m_valid <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    bram_dp_true_1clk #(
        .RAM_WIDTH     (RAM_WIDTH),
        .RAM_ADDR_BITS (RAM_ADDR_BITS)
    ) u_bram (
        .clk_i    (clk_i),
        .en_a_i   (w_push),
        .we_a_i   (w_push),
        .addr_a_i (r_wr_ptr[RAM_ADDR_BITS-1:0]),
        .data_a_i (s_data_i),
        .en_b_i   (w_rd_issue),
        .we_b_i   (1'b0),
        .addr_b_i (r_rd_ptr[RAM_ADDR_BITS-1:0]),
        .data_b_i ('0),
        .data_b_o (w_rd_data)
    );

    assign s_ready_o = w_ready;
    assign m_data_o  = w_rd_data;
    assign m_valid_o = r_m_valid;
    assign count_o   = r_count;

endmodule

// File: tb/tb_bram_fifo_fwft.sv
// Directed self-checking bench for bram_fifo_fwft (DEPTH=8, capacity 9).
module tb_bram_fifo_fwft;
    import bram_fifo_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    fifo_cnt_t   count;

    int n_cmp;
    int n_err;

    bram_fifo_fwft #(
        .RAM_WIDTH     (16),
        .RAM_ADDR_BITS (3)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .flush_i   (flush),
        .s_data_i  (s_data),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .count_o   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q[$];
        logic [15:0] exp_next;
        logic [15:0] wr_val;
        int          mcount;
        int          pushed;
        int          popped;
        int          cyc;
        logic        do_push;
        logic        do_pop;

        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        m_ready = 1'b0;

        #2;
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single push: count at t+1, data at t+2
        s_data  = 16'hA5A5;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("single_cnt1", 32'(count), 32'd1);
        chk("single_val1", 32'(m_valid), 32'd0);
        chk("single_rdy1", 32'(s_ready), 32'd1);
        tick();
        chk("single_val2", 32'(m_valid), 32'd1);
        chk("single_data", 32'(m_data), 32'hA5A5);
        chk("single_rdy2", 32'(s_ready), 32'd1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("single_pop_val", 32'(m_valid), 32'd0);
        chk("single_pop_cnt", 32'(count), 32'd0);

        // Fill with 10 attempts, only 9 fit
        for (int i = 1; i <= 10; i++) begin
            s_data  = 16'(i);
            s_valid = 1'b1;
            tick();
            chk("fill_cnt", 32'(count), (i < 9) ? 32'(i) : 32'd9);
            chk("fill_rdy", 32'(s_ready), (i < 9) ? 32'd1 : 32'd0);
        end
        s_valid = 1'b0;
        chk("full_valid", 32'(m_valid), 32'd1);
        chk("full_head", 32'(m_data), 32'h0001);

        // Drain: one word per cycle, no bubbles
        m_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            chk("drain_valid", 32'(m_valid), 32'd1);
            chk("drain_data", 32'(m_data), 32'(i));
            tick();
        end
        m_ready = 1'b0;
        chk("drain_end_valid", 32'(m_valid), 32'd0);
        chk("drain_end_cnt", 32'(count), 32'd0);
        chk("drain_end_rdy", 32'(s_ready), 32'd1);

        // Streaming across pointer wrap
        exp_next = 16'h0100;
        m_ready  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_data  = 16'h0100 + 16'(i);
            s_valid = 1'b1;
            tick();
            chk("stream_cnt", 32'(count), (i == 0) ? 32'd1 : 32'd2);
            chk("stream_valid", 32'(m_valid), (i == 0) ? 32'd0 : 32'd1);
            if (m_valid) begin
                chk("stream_data", 32'(m_data), 32'(exp_next));
                exp_next = exp_next + 16'd1;
            end
        end
        s_valid = 1'b0;
        // m_data at this point was checked; account for it being popped now
        for (int i = 0; i < 10 && m_valid; i++) begin
            tick();
            if (m_valid) begin
                chk("stream_tail", 32'(m_data), 32'(exp_next));
                exp_next = exp_next + 16'd1;
            end
        end
        m_ready = 1'b0;
        chk("stream_total", 32'(exp_next), 32'h0100 + 32'd40);
        chk("stream_end_cnt", 32'(count), 32'd0);

        // Random ready/valid against a scoreboard
        mcount = 0;
        pushed = 0;
        popped = 0;
        cyc    = 0;
        wr_val = 16'h3000;
        while ((popped < 200) && (cyc < 3000)) begin
            s_valid = (pushed < 200) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
            m_ready = 1'($urandom_range(0, 2) != 0);
            s_data  = wr_val;
            #0;
            if (mcount < 8) chk("rnd_rdy_room", 32'(s_ready), 32'd1);
            if (mcount == 9) chk("rnd_rdy_full", 32'(s_ready), 32'd0);
            do_push = s_valid & s_ready;
            do_pop  = m_valid & m_ready;
            if (do_pop) begin
                chk("rnd_data", 32'(m_data), 32'(q.pop_front()));
                popped++;
            end
            if (do_push) begin
                q.push_back(wr_val);
                wr_val = wr_val + 16'd1;
                pushed++;
            end
            mcount = mcount + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
            tick();
            chk("rnd_cnt", 32'(count), 32'(mcount));
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("rnd_done", 32'(popped), 32'd200);

        // Flush with 5 words stored; same-cycle push dropped
        for (int i = 0; i < 5; i++) begin
            s_data  = 16'h5000 + 16'(i);
            s_valid = 1'b1;
            tick();
        end
        chk("pre_flush_cnt", 32'(count), 32'd5);
        flush   = 1'b1;
        s_data  = 16'hDEAD;
        s_valid = 1'b1;
        m_ready = 1'b1;
        tick();
        flush   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("flush_cnt", 32'(count), 32'd0);
        chk("flush_valid", 32'(m_valid), 32'd0);
        chk("flush_rdy", 32'(s_ready), 32'd1);
        tick();
        tick();
        chk("flush_cnt_hold", 32'(count), 32'd0);
        chk("flush_valid_hold", 32'(m_valid), 32'd0);
        s_data  = 16'hBEEF;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        chk("postflush_valid", 32'(m_valid), 32'd1);
        chk("postflush_data", 32'(m_data), 32'hBEEF);
        chk("postflush_cnt", 32'(count), 32'd1);

        // Async reset between edges
        for (int i = 0; i < 3; i++) begin
            s_data  = 16'h6000 + 16'(i);
            s_valid = 1'b1;
            tick();
        end
        chk("prereset_cnt", 32'(count), 32'd4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", 32'(count), 32'd0);
        chk("arst_valid", 32'(m_valid), 32'd0);
        chk("arst_rdy", 32'(s_ready), 32'd1);
        s_valid = 1'b0;
        tick();
        chk("arst_hold_cnt", 32'(count), 32'd0);
        rst_n = 1'b1;
        tick();
        s_data  = 16'h7777;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("postrst_cnt", 32'(count), 32'd1);
        chk("postrst_val1", 32'(m_valid), 32'd0);
        tick();
        chk("postrst_val2", 32'(m_valid), 32'd1);
        chk("postrst_data", 32'(m_data), 32'h7777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
